// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, tone half-periods,
// FSM state encoding and ROM entry layout.
package melody_pkg;

  localparam int ENTRY_W = 5;  // {code[1:0], beats[2:0]}
  localparam int HP_BITS = 17;

  localparam logic [1:0] NOTE_REST = 2'd0;
  localparam logic [1:0] NOTE_C4   = 2'd1;
  localparam logic [1:0] NOTE_F4   = 2'd2;
  localparam logic [1:0] NOTE_C5   = 2'd3;

  localparam logic [HP_BITS-1:0] HP_C4 = 17'd95785;
  localparam logic [HP_BITS-1:0] HP_F4 = 17'd71633;
  localparam logic [HP_BITS-1:0] HP_C5 = 17'd47801;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_e;

  function automatic logic [HP_BITS-1:0] note_half_period(input logic [1:0] code);
    logic [HP_BITS-1:0] hp;
    case (code)
      NOTE_C4: hp = HP_C4;
      NOTE_F4: hp = HP_F4;
      NOTE_C5: hp = HP_C5;
      default: hp = '0;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Fixed 8-note melody table; swap the entries here to change the tune
// without touching the sequencer FSM.
module melody_rom
  import melody_pkg::*;
(
  input  logic [2:0]         idx_i,
  output logic [ENTRY_W-1:0] entry_o
);

  always_comb begin
    entry_o = '0;
    case (idx_i)
      3'd0: entry_o = {NOTE_C4,   3'd2};
      3'd1: entry_o = {NOTE_C4,   3'd1};
      3'd2: entry_o = {NOTE_F4,   3'd2};
      3'd3: entry_o = {NOTE_C5,   3'd2};
      3'd4: entry_o = {NOTE_REST, 3'd1};
      3'd5: entry_o = {NOTE_F4,   3'd1};
      3'd6: entry_o = {NOTE_C4,   3'd2};
      3'd7: entry_o = {NOTE_C5,   3'd4};
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer driving the buzzer tone generator with a half-period and enable.
// Define MELODY_LOOP_EN to replay the melody continuously until stop/reset.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int HP_W        = 17
) (
  input  logic            clk_50MHz,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  output logic [HP_W-1:0] half_period,
  output logic            tone_en,
  output logic [2:0]      note_idx,
  output logic            busy,
  output logic            done
);

  // Counter is sized to hold the longest possible note (7 beats) or the gap.
  localparam int CNT_W = $clog2(7 * BEAT_CYCLES + GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] BEAT_L = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_L  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HP_W-1:0]   half_period_q;
  logic              tone_en_q;
  logic [2:0]        note_idx_q;
  logic              busy_q;
  logic              done_q;

  logic [ENTRY_W-1:0] rom_entry;
  logic [1:0]         rom_code;
  logic [2:0]         rom_beats;
  logic [2:0]         beats_eff;
  logic [CNT_W-1:0]   dur_d;
  state_e             adv_state_d;
  logic [2:0]         adv_idx_d;
  logic               adv_done_d;

  melody_rom u_rom (
    .idx_i   (note_idx_q),
    .entry_o (rom_entry)
  );

  assign rom_code  = rom_entry[ENTRY_W-1:3];
  assign rom_beats = rom_entry[2:0];

  // Note-end decision: next LOAD, or completion after the last note.
  always_comb begin
    beats_eff   = (rom_beats == 3'd0) ? 3'd1 : rom_beats;
    dur_d       = BEAT_L * CNT_W'(beats_eff) - CNT_W'(1);
    adv_done_d  = (note_idx_q == 3'd7);
`ifdef MELODY_LOOP_EN
    adv_state_d = LOAD;
    adv_idx_d   = note_idx_q + 3'd1;
`else
    adv_state_d = (note_idx_q == 3'd7) ? DONE : LOAD;
    adv_idx_d   = (note_idx_q == 3'd7) ? note_idx_q : note_idx_q + 3'd1;
`endif
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset || stop) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      half_period_q <= '0;
      tone_en_q     <= 1'b0;
      note_idx_q    <= 3'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= LOAD;
            note_idx_q <= 3'd0;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          cnt_q         <= dur_d;
          half_period_q <= HP_W'(note_half_period(rom_code));
          tone_en_q     <= (rom_code != NOTE_REST);
          done_q        <= 1'b0;
          state_q       <= PLAY;
        end
        PLAY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            half_period_q <= '0;
            tone_en_q     <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              cnt_q   <= GAP_L;
            end else begin
              state_q    <= adv_state_d;
              note_idx_q <= adv_idx_d;
              done_q     <= adv_done_d;
            end
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q    <= adv_state_d;
            note_idx_q <= adv_idx_d;
            done_q     <= adv_done_d;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          note_idx_q <= 3'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign half_period = half_period_q;
  assign tone_en     = tone_en_q;
  assign note_idx    = note_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: expected per-cycle output words are
// queued when start is accepted and compared one per clock.
module tb_melody_sequencer;

  localparam int BEAT = 10;
  localparam int GAPC = 2;

  logic        clk_50MHz = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [16:0] half_period;
  logic        tone_en;
  logic [2:0]  note_idx;
  logic        busy;
  logic        done;

  always #10 clk_50MHz = ~clk_50MHz;

  melody_sequencer #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAPC),
    .HP_W        (17)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .tone_en     (tone_en),
    .note_idx    (note_idx),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  string phase = "reset";
  logic [31:0] sb_q[$];
  logic looping = 1'b0;
  logic last_busy = 1'b0;

  int mel_code[8]  = '{1, 1, 2, 3, 0, 2, 1, 3};
  int mel_beats[8] = '{2, 1, 2, 2, 1, 1, 2, 4};

  function automatic logic [16:0] hp_of(input int code);
    case (code)
      1: return 17'd95785;
      2: return 17'd71633;
      3: return 17'd47801;
      default: return 17'd0;
    endcase
  endfunction

  // Word layout: done[22] busy[21] tone[20] idx[19:17] hp[16:0]
  function automatic logic [31:0] pack(input logic d, input logic b, input logic t,
                                       input logic [2:0] i, input logic [16:0] hp);
    return {9'd0, d, b, t, i, hp};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got done=%0b busy=%0b tone=%0b idx=%0d hp=%0d, expected done=%0b busy=%0b tone=%0b idx=%0d hp=%0d",
               tag, cyc, obs[22], obs[21], obs[20], obs[19:17], obs[16:0],
               exp[22], exp[21], exp[20], exp[19:17], exp[16:0]);
    end
  endtask

  task automatic push_pass(input logic first_done);
    for (int i = 0; i < 8; i++) begin
      int b;
      b = (mel_beats[i] == 0) ? 1 : mel_beats[i];
      sb_q.push_back(pack(first_done && (i == 0), 1'b1, 1'b0, 3'(i), 17'd0));
      for (int k = 0; k < b * BEAT; k++)
        sb_q.push_back(pack(1'b0, 1'b1, mel_code[i] != 0, 3'(i), hp_of(mel_code[i])));
      for (int k = 0; k < GAPC; k++)
        sb_q.push_back(pack(1'b0, 1'b1, 1'b0, 3'(i), 17'd0));
    end
  endtask

  task automatic step(input logic s, input logic p);
    logic [31:0] exp;
    start = s;
    stop  = p;
    if (s || p) $display("cycle %0d [%s]: drive start=%0b stop=%0b", cyc, phase, s, p);
    if (p) begin
      sb_q.delete();
      looping = 1'b0;
    end else if (s && !last_busy) begin
      push_pass(1'b0);
`ifdef MELODY_LOOP_EN
      looping = 1'b1;
`else
      sb_q.push_back(pack(1'b1, 1'b1, 1'b0, 3'd7, 17'd0));
`endif
    end
    @(posedge clk_50MHz);
    #1;
    cyc++;
    start = 1'b0;
    stop  = 1'b0;
    if (sb_q.size() == 0 && looping) push_pass(1'b1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'd0;
    check_eq(phase, pack(done, busy, tone_en, note_idx, half_period), exp);
    last_busy = exp[21];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_50MHz);
      #1;
      check_eq("reset", pack(done, busy, tone_en, note_idx, half_period), 32'd0);
    end
    reset = 1'b0;
    cyc = 0;

    phase = "idle";
    run(20);

    // Full melody from a single pulse; long enough to cover a second loop pass.
    phase = "single_pulse";
    cyc = -1;
    step(1'b1, 1'b0);
    run(360);
    phase = "stop_after_run";
    step(1'b0, 1'b1);
    run(5);

    // Abort during idx 2 PLAY, then restart from idx 0.
    phase = "stop_mid";
    step(1'b1, 1'b0);
    run(44);
    step(1'b0, 1'b1);
    run(5);
    phase = "restart";
    step(1'b1, 1'b0);
    run(30);
    phase = "repeat_start";
    step(1'b1, 1'b0);
    run(150);
    step(1'b0, 1'b1);
    run(3);

    phase = "start_and_stop";
    step(1'b1, 1'b1);
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
